stall_control: RTL and testbench

Pipeline interlock for the five-stage processor. It covers the hazards that forwarding cannot resolve. It detects load-use dependencies between the decode and execute stages, and sequences multi-cycle mult/div operations through the multdiv unit by holding the front of the pipeline until the result is ready. It sits beside the bypass logic, drives the stall/NOP controls of the PC, F/D, D/X and X/M latches, and hands multdiv results and exceptions to the X/M latch.

---
 rtl/stall_control_pkg.sv | 27 ++
 rtl/stall_control_src_decode.sv | 53 +++++
 rtl/stall_control.sv | 171 +++++++++++++++++
 tb/tb_stall_control.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stall_control_pkg.sv
// Shared decode constants and FSM state type for the pipeline interlock.
package stall_control_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [4:0] REG_STATUS = 5'd30;

  typedef enum logic {StIdle, StBusy} md_state_e;

  function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
    return ir[31:27];
  endfunction

endpackage

// File: rtl/stall_control_src_decode.sv
// Maps an instruction to the register numbers it reads, with per-source valid bits.
module src_decode
  import stall_control_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  src1_o,
  output logic [4:0]  src2_o,
  output logic        src1_vld_o,
  output logic        src2_vld_o
);

  logic [4:0] rd, rs, rt;

  assign rd = instr_i[26:22];
  assign rs = instr_i[21:17];
  assign rt = instr_i[16:12];

  always_comb begin
    src1_o     = 5'd0;
    src2_o     = 5'd0;
    src1_vld_o = 1'b0;
    src2_vld_o = 1'b0;
    unique case (ir_opcode(instr_i))
      OP_RTYPE: begin
        src1_o     = rs;
        src2_o     = rt;
        src1_vld_o = 1'b1;
        src2_vld_o = 1'b1;
      end
      // sw data comes through W->M forwarding, so only the base is a source here
      OP_ADDI, OP_LW, OP_SW: begin
        src1_o     = rs;
        src1_vld_o = 1'b1;
      end
      OP_BNE, OP_BLT: begin
        src1_o     = rd;
        src2_o     = rs;
        src1_vld_o = 1'b1;
        src2_vld_o = 1'b1;
      end
      OP_BEX: begin
        src1_o     = REG_STATUS;
        src1_vld_o = 1'b1;
      end
      OP_JR: begin
        src1_o     = rd;
        src1_vld_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stall_control.sv
// Load-use and mult/div interlock for the five-stage pipeline.
// Optional STALL_PERF_EN adds saturating stall-cycle and md-op counters.
module stall_control
  import stall_control_pkg::*;
#(
  parameter int unsigned MdTimeout = 40
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] fd_ir_i,
  input  logic [31:0] dx_ir_i,
  input  logic        flush_i,
  input  logic        md_ready_i,
  input  logic        md_exception_i,
`ifdef STALL_PERF_EN
  output logic [31:0] perf_stall_cycles_o,
  output logic [15:0] perf_md_ops_o,
`endif
  output logic        stall_f_o,
  output logic        stall_d_o,
  output logic        nop_dx_o,
  output logic        nop_xm_o,
  output logic        md_ctrl_mult_o,
  output logic        md_ctrl_div_o,
  output logic        md_busy_o,
  output logic        md_done_o,
  output logic        md_exc_o,
  output logic [4:0]  md_rd_o
);

  localparam int unsigned CntW = (MdTimeout > 1) ? $clog2(MdTimeout) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MdTimeout - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  md_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]    md_rd_q, md_rd_d;

  logic [4:0] src1, src2;
  logic       src1_vld, src2_vld;

  src_decode u_src_decode (
    .instr_i    (fd_ir_i),
    .src1_o     (src1),
    .src2_o     (src2),
    .src1_vld_o (src1_vld),
    .src2_vld_o (src2_vld)
  );

  logic [4:0] dx_rd;
  logic       dx_is_md, dx_is_mult, load_use;

  assign dx_rd      = dx_ir_i[26:22];
  assign dx_is_md   = (ir_opcode(dx_ir_i) == OP_RTYPE) &&
                      ((dx_ir_i[6:2] == ALU_MULT) || (dx_ir_i[6:2] == ALU_DIV));
  assign dx_is_mult = dx_ir_i[6:2] == ALU_MULT;
  assign load_use   = (ir_opcode(dx_ir_i) == OP_LW) && (dx_rd != 5'd0) &&
                      ((src1_vld && (src1 == dx_rd)) || (src2_vld && (src2 == dx_rd)));

  logic stall_f, stall_d, nop_dx, nop_xm, ctrl_mult, ctrl_div, busy, done, exc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_rd_d   = md_rd_q;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    nop_dx    = 1'b0;
    nop_xm    = 1'b0;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    exc       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!flush_i) begin
          if (dx_is_md) begin
            ctrl_mult = dx_is_mult;
            ctrl_div  = !dx_is_mult;
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            nop_xm    = 1'b1;
            md_rd_d   = dx_rd;
            cnt_d     = '0;
            state_d   = StBusy;
          end else if (load_use) begin
            stall_f = 1'b1;
            nop_dx  = 1'b1;
          end
        end
      end
      StBusy: begin
        busy = 1'b1;
        if (md_ready_i) begin
          done    = 1'b1;
          exc     = md_exception_i;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          done    = 1'b1;
          exc     = 1'b1;
          state_d = StIdle;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          nop_xm  = 1'b1;
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Outputs are held quiet while reset is asserted so an aborted op never signals done
    if (!rst_ni) begin
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      nop_dx    = 1'b0;
      nop_xm    = 1'b0;
      ctrl_mult = 1'b0;
      ctrl_div  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      exc       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      md_rd_q <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_rd_q <= md_rd_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_cycles_q;
  logic [15:0] perf_md_ops_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_stall_cycles_q <= 32'd0;
      perf_md_ops_q       <= 16'd0;
    end else begin
      if (stall_f && (perf_stall_cycles_q != 32'hFFFF_FFFF)) begin
        perf_stall_cycles_q <= perf_stall_cycles_q + 32'd1;
      end
      if (done && (perf_md_ops_q != 16'hFFFF)) begin
        perf_md_ops_q <= perf_md_ops_q + 16'd1;
      end
    end
  end

  assign perf_stall_cycles_o = perf_stall_cycles_q;
  assign perf_md_ops_o       = perf_md_ops_q;
`endif

  assign stall_f_o      = stall_f;
  assign stall_d_o      = stall_d;
  assign nop_dx_o       = nop_dx;
  assign nop_xm_o       = nop_xm;
  assign md_ctrl_mult_o = ctrl_mult;
  assign md_ctrl_div_o  = ctrl_div;
  assign md_busy_o      = busy;
  assign md_done_o      = done;
  assign md_exc_o       = exc;
  assign md_rd_o        = md_rd_q;

endmodule

// File: tb/tb_stall_control.sv
// Directed self-checking bench for stall_control (default build).
module tb_stall_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fd_ir, dx_ir;
  logic        flush, md_ready, md_exception;
  logic        stall_f, stall_d, nop_dx, nop_xm, ctrl_mult, ctrl_div;
  logic        md_busy, md_done, md_exc;
  logic [4:0]  md_rd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stall_control #(.MdTimeout(40)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .fd_ir_i        (fd_ir),
    .dx_ir_i        (dx_ir),
    .flush_i        (flush),
    .md_ready_i     (md_ready),
    .md_exception_i (md_exception),
    .stall_f_o      (stall_f),
    .stall_d_o      (stall_d),
    .nop_dx_o       (nop_dx),
    .nop_xm_o       (nop_xm),
    .md_ctrl_mult_o (ctrl_mult),
    .md_ctrl_div_o  (ctrl_div),
    .md_busy_o      (md_busy),
    .md_done_o      (md_done),
    .md_exc_o       (md_exc),
    .md_rd_o        (md_rd)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] aluop);
    return {5'b00000, rd, rs, rt, 5'd0, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs);
    return {op, rd, rs, 17'd0};
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fd_ir = '0; dx_ir = '0; flush = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
    cycle(); cycle();
    check_eq("reset_stall_f", {31'd0, stall_f}, 0);
    rst_n = 1'b1;
    settle();
    check_eq("rst_busy", {31'd0, md_busy}, 0);
    check_eq("rst_md_rd", {27'd0, md_rd}, 0);
    check_eq("rst_nop_dx", {31'd0, nop_dx}, 0);

    // lw r5,0(r2) ; add r7,r5,r3
    dx_ir = itype(5'b01000, 5'd5, 5'd2);
    fd_ir = rtype(5'd7, 5'd5, 5'd3, 5'd0);
    settle();
    check_eq("lu_stall_f", {31'd0, stall_f}, 1);
    check_eq("lu_nop_dx", {31'd0, nop_dx}, 1);
    check_eq("lu_stall_d", {31'd0, stall_d}, 0);
    cycle();
    dx_ir = '0;
    settle();
    check_eq("lu_release", {31'd0, stall_f | nop_dx}, 0);

    // sw data field is exempt, sw base is not
    dx_ir = itype(5'b01000, 5'd5, 5'd2);
    fd_ir = itype(5'b00111, 5'd5, 5'd4);
    settle();
    check_eq("sw_data_nostall", {31'd0, stall_f}, 0);
    fd_ir = itype(5'b00111, 5'd1, 5'd5);
    settle();
    check_eq("sw_base_stall", {31'd0, stall_f}, 1);

    // branch sources rd; bex sources r30
    fd_ir = itype(5'b00010, 5'd5, 5'd1);
    settle();
    check_eq("bne_rd_stall", {31'd0, nop_dx}, 1);
    dx_ir = itype(5'b01000, 5'd30, 5'd2);
    fd_ir = {5'b10110, 27'd0};
    settle();
    check_eq("bex_r30_stall", {31'd0, stall_f}, 1);

    // lw r0 never stalls
    dx_ir = itype(5'b01000, 5'd0, 5'd2);
    fd_ir = rtype(5'd1, 5'd0, 5'd0, 5'd0);
    settle();
    check_eq("r0_nostall", {31'd0, stall_f}, 0);

    // flush suppresses a load-use stall
    dx_ir = itype(5'b01000, 5'd5, 5'd2);
    fd_ir = rtype(5'd7, 5'd5, 5'd3, 5'd0);
    flush = 1'b1;
    settle();
    check_eq("flush_lu", {31'd0, stall_f | nop_dx}, 0);
    flush = 1'b0;
    fd_ir = '0;
    dx_ir = '0;
    cycle();

    // mult r4,r2,r3 completing at T+17
    dx_ir = rtype(5'd4, 5'd2, 5'd3, 5'b00110);
    settle();
    check_eq("mult_pulse_T", {31'd0, ctrl_mult}, 1);
    check_eq("mult_div_T", {31'd0, ctrl_div}, 0);
    check_eq("mult_stalls_T", {29'd0, stall_f, stall_d, nop_xm}, 32'h7);
    for (int i = 1; i <= 16; i++) begin
      cycle();
      check_eq("mult_hold", {27'd0, ctrl_mult, md_busy, stall_f, stall_d, nop_xm}, 32'hF);
    end
    cycle();
    md_ready = 1'b1;
    settle();
    check_eq("mult_done", {31'd0, md_done}, 1);
    check_eq("mult_exc", {31'd0, md_exc}, 0);
    check_eq("mult_rd", {27'd0, md_rd}, 4);
    check_eq("mult_release", {29'd0, stall_f, stall_d, nop_xm}, 0);
    cycle();
    md_ready = 1'b0;
    dx_ir = '0;
    settle();
    check_eq("mult_idle", {30'd0, md_busy, md_done}, 0);

    // div r6,r1,r0 with exception at T+3
    dx_ir = rtype(5'd6, 5'd1, 5'd0, 5'b00111);
    settle();
    check_eq("div_pulse", {30'd0, ctrl_mult, ctrl_div}, 1);
    cycle(); cycle();
    check_eq("div_T2_nodone", {31'd0, md_done}, 0);
    cycle();
    md_ready = 1'b1;
    md_exception = 1'b1;
    settle();
    check_eq("div_exc_done", {30'd0, md_done, md_exc}, 3);
    check_eq("div_rd", {27'd0, md_rd}, 6);
    cycle();
    md_ready = 1'b0;
    md_exception = 1'b0;
    dx_ir = '0;
    settle();

    // timeout: done+exc exactly 40 cycles after start
    dx_ir = rtype(5'd9, 5'd2, 5'd3, 5'b00110);
    settle();
    check_eq("to_start", {31'd0, ctrl_mult}, 1);
    cycle();
    dx_ir = '0;
    begin
      int early = 0;
      for (int i = 1; i < 40; i++) begin
        if (md_done) early++;
        cycle();
      end
      check_eq("to_no_early_done", early, 0);
    end
    check_eq("to_done_exc", {30'd0, md_done, md_exc}, 3);
    check_eq("to_release", {31'd0, stall_f}, 0);
    cycle();
    md_ready = 1'b1;
    settle();
    check_eq("to_stale_ready", {30'd0, md_done, md_busy}, 0);
    md_ready = 1'b0;

    // flush with a mult in D/X: no start
    dx_ir = rtype(5'd4, 5'd2, 5'd3, 5'b00110);
    flush = 1'b1;
    settle();
    check_eq("flush_md", {30'd0, ctrl_mult, stall_f}, 0);
    cycle();
    flush = 1'b0;
    dx_ir = '0;
    settle();
    check_eq("flush_md_idle", {31'd0, md_busy}, 0);

    // reset mid-BUSY aborts silently
    dx_ir = rtype(5'd11, 5'd2, 5'd3, 5'b00110);
    cycle();
    dx_ir = '0;
    cycle(); cycle();
    check_eq("rb_busy", {31'd0, md_busy}, 1);
    rst_n = 1'b0;
    settle();
    check_eq("rb_no_done", {31'd0, md_done}, 0);
    cycle();
    check_eq("rb_outputs", {24'd0, stall_f, stall_d, nop_dx, nop_xm, ctrl_mult, ctrl_div,
                            md_busy, md_done}, 0);
    check_eq("rb_md_rd", {27'd0, md_rd}, 0);
    rst_n = 1'b1;
    settle();
    check_eq("rb_idle", {31'd0, md_busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
